// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-type codes used by fetch and decode, the
// reset fetch address and the fetch-stage state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    localparam logic [3:0] BT_BEQ = 4'b0001;
    localparam logic [3:0] BT_BNE = 4'b0000;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_sram_if.sv
// Request/acknowledge port between the fetch stage and the instruction SRAM.
// Only one request is outstanding at a time.
interface inst_sram_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input  ack, rdata);
    modport slave  (input  req, addr, output ack, rdata);

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational redirect decision for the control-transfer instruction that
// decode is presenting: whether it is taken, and where it goes.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [31:0] de_pc,
    input  logic        de_is_b,
    input  logic        de_is_j,
    input  logic        de_is_jr,
    input  logic [3:0]  de_b_type,
    input  logic [15:0] de_b_offset,
    input  logic [25:0] de_j_index,
    input  logic [31:0] de_rs_value,
    input  logic [31:0] de_rt_value,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] seq_pc;
    logic [31:0] br_disp;

    assign seq_pc  = de_pc + 32'd4;
    assign br_disp = {{14{de_b_offset[15]}}, de_b_offset, 2'b00};

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves it unassigned, which would infer a latch.
        taken  = 1'b0;
        target = seq_pc;
        if (de_is_b) begin
            taken  = ((de_b_type == BT_BEQ) && (de_rs_value == de_rt_value)) ||
                     ((de_b_type == BT_BNE) && (de_rs_value != de_rt_value));
            target = seq_pc + br_disp;
        end else if (de_is_j) begin
            taken  = 1'b1;
            target = {seq_pc[31:28], de_j_index, 2'b00};
        end else if (de_is_jr) begin
            taken  = 1'b1;
            target = de_rs_value;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one SRAM request at a
// time, holds the word for decode and applies delay-slot redirects.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    inst_sram_if.master        inst_sram,
    output logic               fe_valid,
    output logic [31:0]        fe_inst,
    output logic [31:0]        current_pc,
    input  logic               de_allowin,
    input  logic               de_br_valid,
    input  logic [31:0]        de_pc,
    input  logic               de_is_b,
    input  logic               de_is_j,
    input  logic               de_is_jr,
    input  logic [3:0]         de_b_type,
    input  logic [15:0]        de_b_offset,
    input  logic [25:0]        de_j_index,
    input  logic [31:0]        de_rs_value,
    input  logic [31:0]        de_rt_value
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic         req_q;
    logic         redir_pending;
    logic [31:0]  redir_target;

    logic         br_taken;
    logic [31:0]  br_target;
    logic         redirect_now;
    logic         transfer;
    logic [31:0]  next_pc;

    fetch_next_pc u_next_pc (
        .de_pc       (de_pc),
        .de_is_b     (de_is_b),
        .de_is_j     (de_is_j),
        .de_is_jr    (de_is_jr),
        .de_b_type   (de_b_type),
        .de_b_offset (de_b_offset),
        .de_j_index  (de_j_index),
        .de_rs_value (de_rs_value),
        .de_rt_value (de_rt_value),
        .taken       (br_taken),
        .target      (br_target)
    );

    assign inst_sram.req  = req_q;
    assign inst_sram.addr = fetch_pc;

    assign redirect_now = de_br_valid & br_taken;
    assign transfer     = fe_valid & de_allowin;

    // A redirect resolved in the same cycle as the delay-slot transfer is
    // bypassed straight into the next fetch address.
    always_comb begin
        next_pc = fetch_pc + 32'd4;
        if (redirect_now) begin
            next_pc = br_target;
        end else if (redir_pending) begin
            next_pc = redir_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FS_BOOT;
            fetch_pc      <= RESET_PC;
            req_q         <= 1'b0;
            fe_valid      <= 1'b0;
            fe_inst       <= 32'd0;
            current_pc    <= 32'd0;
            redir_pending <= 1'b0;
            redir_target  <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge value of every other one, independent of order.
            if (transfer) begin
                redir_pending <= 1'b0;
            end else if (redirect_now) begin
                redir_pending <= 1'b1;
                redir_target  <= br_target;
            end

            case (state)
                FS_BOOT: begin
                    state <= FS_REQ;
                    req_q <= 1'b1;
                end
                FS_REQ: begin
                    if (inst_sram.ack) begin
                        fe_inst    <= inst_sram.rdata;
                        current_pc <= fetch_pc;
                        fe_valid   <= 1'b1;
                        req_q      <= 1'b0;
                        state      <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (transfer) begin
                        fe_valid <= 1'b0;
                        fetch_pc <= next_pc;
                        req_q    <= 1'b1;
                        state    <= FS_REQ;
                    end
                end
                default: begin
                    state    <= FS_BOOT;
                    req_q    <= 1'b0;
                    fe_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, SRAM wait states, decode
// back-pressure, delay-slot redirects and reset/stale-ack behaviour.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] current_pc;
    logic        de_allowin;
    logic        de_br_valid;
    logic [31:0] de_pc;
    logic        de_is_b;
    logic        de_is_j;
    logic        de_is_jr;
    logic [3:0]  de_b_type;
    logic [15:0] de_b_offset;
    logic [25:0] de_j_index;
    logic [31:0] de_rs_value;
    logic [31:0] de_rt_value;

    int n_cmp = 0;
    int n_err = 0;

    inst_sram_if sram ();

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .inst_sram   (sram),
        .fe_valid    (fe_valid),
        .fe_inst     (fe_inst),
        .current_pc  (current_pc),
        .de_allowin  (de_allowin),
        .de_br_valid (de_br_valid),
        .de_pc       (de_pc),
        .de_is_b     (de_is_b),
        .de_is_j     (de_is_j),
        .de_is_jr    (de_is_jr),
        .de_b_type   (de_b_type),
        .de_b_offset (de_b_offset),
        .de_j_index  (de_j_index),
        .de_rs_value (de_rs_value),
        .de_rt_value (de_rt_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_fe_valid", {31'd0, fe_valid}, 32'd0);
        check("rst_fe_inst", fe_inst, 32'd0);
        check("rst_current_pc", current_pc, 32'd0);
        check("rst_req", {31'd0, sram.req}, 32'd0);
        check("rst_addr", sram.addr, 32'hbfc0_0000);
        step();
        reset = 1'b0;
    endtask

    // Expects a request already showing; serves it after 'waits' idle cycles.
    task automatic fetch_one(input int waits, input logic [31:0] addr, input logic [31:0] data);
        check("req_hi", {31'd0, sram.req}, 32'd1);
        check("req_addr", sram.addr, addr);
        for (int i = 0; i < waits; i++) begin
            step();
            check("wait_req", {31'd0, sram.req}, 32'd1);
            check("wait_addr", sram.addr, addr);
            check("wait_valid", {31'd0, fe_valid}, 32'd0);
        end
        sram.ack   = 1'b1;
        sram.rdata = data;
        step();
        sram.ack   = 1'b0;
        sram.rdata = 32'd0;
        check("got_valid", {31'd0, fe_valid}, 32'd1);
        check("got_inst", fe_inst, data);
        check("got_pc", current_pc, addr);
        check("got_req_lo", {31'd0, sram.req}, 32'd0);
    endtask

    task automatic xfer();
        de_allowin = 1'b1;
        step();
        de_allowin = 1'b0;
        check("xfer_valid_lo", {31'd0, fe_valid}, 32'd0);
    endtask

    task automatic set_br(input logic b, input logic j, input logic jr, input logic [3:0] bt,
                          input logic [31:0] pc, input logic [15:0] off, input logic [25:0] idx,
                          input logic [31:0] rs, input logic [31:0] rt);
        de_br_valid = 1'b1;
        de_is_b     = b;
        de_is_j     = j;
        de_is_jr    = jr;
        de_b_type   = bt;
        de_pc       = pc;
        de_b_offset = off;
        de_j_index  = idx;
        de_rs_value = rs;
        de_rt_value = rt;
    endtask

    task automatic clear_br();
        de_br_valid = 1'b0;
        de_is_b     = 1'b0;
        de_is_j     = 1'b0;
        de_is_jr    = 1'b0;
        de_b_type   = 4'hf;
        de_pc       = 32'd0;
        de_b_offset = 16'd0;
        de_j_index  = 26'd0;
        de_rs_value = 32'd0;
        de_rt_value = 32'd0;
    endtask

    initial begin
        reset      = 1'b1;
        de_allowin = 1'b0;
        sram.ack   = 1'b0;
        sram.rdata = 32'd0;
        clear_br();
        step();

        // Reset release: BOOT lasts exactly one cycle.
        do_reset();
        step();

        // Zero-wait sequential fetch.
        for (int i = 0; i < 3; i++) begin
            fetch_one(0, 32'hbfc0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            xfer();
        end

        // Three wait states.
        fetch_one(3, 32'hbfc0_000c, 32'h1000_000c);
        xfer();

        // Decode back-pressure for four cycles.
        fetch_one(0, 32'hbfc0_0010, 32'h1000_0010);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_inst", fe_inst, 32'h1000_0010);
            check("hold_valid", {31'd0, fe_valid}, 32'd1);
            check("hold_no_req", {31'd0, sram.req}, 32'd0);
        end
        xfer();

        // BEQ taken at bfc00010: delay slot bfc00014, then bfc00024.
        fetch_one(0, 32'hbfc0_0014, 32'h1000_0014);
        set_br(1'b1, 1'b0, 1'b0, 4'b0001, 32'hbfc0_0010, 16'h0004, 26'd0, 32'd5, 32'd5);
        step();
        clear_br();
        xfer();
        fetch_one(0, 32'hbfc0_0024, 32'h1000_0024);
        xfer();

        // JR strobed on the delay-slot transfer cycle: bypass path.
        fetch_one(0, 32'hbfc0_0028, 32'h1000_0028);
        set_br(1'b0, 1'b0, 1'b1, 4'hf, 32'hbfc0_0024, 16'd0, 26'd0, 32'h8000_1000, 32'd0);
        de_allowin = 1'b1;
        step();
        de_allowin = 1'b0;
        clear_br();
        check("jr_valid_lo", {31'd0, fe_valid}, 32'd0);
        fetch_one(0, 32'h8000_1000, 32'h2000_0000);
        xfer();
        fetch_one(0, 32'h8000_1004, 32'h2000_0004);

        // J at bfc00100, index 0x40 -> b0000100.
        set_br(1'b0, 1'b1, 1'b0, 4'hf, 32'hbfc0_0100, 16'd0, 26'h000_0040, 32'd0, 32'd0);
        step();
        clear_br();
        xfer();
        fetch_one(0, 32'hb000_0100, 32'h3000_0100);
        xfer();

        // BNE taken with negative offset: b0000104 - 16 = b00000f4.
        fetch_one(0, 32'hb000_0104, 32'h3000_0104);
        set_br(1'b1, 1'b0, 1'b0, 4'b0000, 32'hb000_0100, 16'hfffc, 26'd0, 32'd1, 32'd2);
        step();
        clear_br();
        xfer();
        fetch_one(0, 32'hb000_00f4, 32'h3000_00f4);

        // Unknown branch type is never taken, even with equal operands.
        set_br(1'b1, 1'b0, 1'b0, 4'b0010, 32'hb000_00f0, 16'h0100, 26'd0, 32'd7, 32'd7);
        step();
        clear_br();
        xfer();
        fetch_one(0, 32'hb000_00f8, 32'h3000_00f8);

        // Pending redirect set in HOLD, then reset: redirect must be dropped.
        set_br(1'b0, 1'b1, 1'b0, 4'hf, 32'hbfc0_0100, 16'd0, 26'h000_0040, 32'd0, 32'd0);
        step();
        clear_br();
        do_reset();
        step();
        fetch_one(0, 32'hbfc0_0000, 32'h1000_0000);
        xfer();
        fetch_one(0, 32'hbfc0_0004, 32'h1000_0004);
        xfer();
        fetch_one(0, 32'hbfc0_0008, 32'h1000_0008);
        xfer();
        fetch_one(0, 32'hbfc0_000c, 32'h1000_000c);
        xfer();
        fetch_one(0, 32'hbfc0_0010, 32'h1000_0010);
        xfer();

        // BEQ not taken (rs != rt): delay slot bfc00014, then bfc00018.
        fetch_one(0, 32'hbfc0_0014, 32'h1000_0014);
        set_br(1'b1, 1'b0, 1'b0, 4'b0001, 32'hbfc0_0010, 16'h0004, 26'd0, 32'd5, 32'd6);
        step();
        clear_br();
        xfer();
        fetch_one(0, 32'hbfc0_0018, 32'h1000_0018);
        xfer();
        check("pre_rst_req", {31'd0, sram.req}, 32'd1);

        // Reset in REQ, then a stray ack during BOOT is ignored.
        do_reset();
        sram.ack   = 1'b1;
        sram.rdata = 32'hdead_beef;
        step();
        sram.ack   = 1'b0;
        sram.rdata = 32'd0;
        check("stale_valid", {31'd0, fe_valid}, 32'd0);
        check("stale_inst", fe_inst, 32'd0);
        check("stale_req", {31'd0, sram.req}, 32'd1);
        check("stale_addr", sram.addr, 32'hbfc0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
